// File: rtl/fixedpoint_pkg.sv
// Q8.8 fixed-point type shared by the learning datapath, plus a clamp helper
// that narrows a wide signed intermediate into fixed_point_t.
package fixedpoint;

  localparam int FP_W        = 16;
  localparam int FP_FRAC     = 8;
  localparam int FP_SAT_IN_W = 32;

  typedef logic signed [FP_W-1:0] fixed_point_t;

  localparam fixed_point_t FP_MAX = {1'b0, {(FP_W-1){1'b1}}};
  localparam fixed_point_t FP_MIN = {1'b1, {(FP_W-1){1'b0}}};

  function automatic fixed_point_t fp_sat(input logic signed [FP_SAT_IN_W-1:0] v);
    logic signed [FP_SAT_IN_W-1:0] hi;
    logic signed [FP_SAT_IN_W-1:0] lo;
    hi = FP_SAT_IN_W'(FP_MAX);
    lo = FP_SAT_IN_W'(FP_MIN);
    if (v > hi)      return FP_MAX;
    else if (v < lo) return FP_MIN;
    else             return v[FP_W-1:0];
  endfunction

endpackage

// File: rtl/fp_sat_add.sv
// Combinational weight + accumulator adder for the commit sweep.
// WU_SATURATE_EN selects clamping to the fixed_point_t range; otherwise the sum wraps.
module fp_sat_add
  import fixedpoint::*;
#(
  parameter int ACC_W = 20
) (
  input  logic signed [ACC_W-1:0] acc,
  input  fixed_point_t            weight,
  output fixed_point_t            sum
);

  logic signed [ACC_W:0] sum_wide;

  always_comb begin
    sum_wide = $signed({acc[ACC_W-1], acc}) + (ACC_W+1)'(weight);
  end

`ifdef WU_SATURATE_EN
  assign sum = fp_sat(FP_SAT_IN_W'(sum_wide));
`else
  logic wrap_unused_bits;
  assign wrap_unused_bits = ^sum_wide[ACC_W:FP_W];
  assign sum = sum_wide[FP_W-1:0];
`endif

endmodule

// File: rtl/weight_update_unit.sv
// Weight store fed by the delta stream: per-weight saturating accumulators summed
// during a batch, applied one weight per cycle on commit (WU_SATURATE_EN selects clamp vs wrap).
module weight_update_unit
  import fixedpoint::*;
#(
  parameter int N_WEIGHTS  = 8,
  parameter int GUARD_BITS = 4,
  localparam int IW        = $clog2(N_WEIGHTS) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 delta_valid,
  output logic                 delta_ready,
  input  logic [IW-1:0]        delta_idx,
  input  logic [FP_W-1:0]      weight_delta,
  input  logic                 ld_valid,
  input  logic [IW-1:0]        ld_idx,
  input  logic [FP_W-1:0]      ld_weight,
  input  logic                 commit,
  output logic                 busy,
  output logic                 done,
  input  logic [IW-1:0]        rd_idx,
  output logic [FP_W-1:0]      rd_weight,
  output logic                 idx_err
);

  localparam int SW    = $clog2(N_WEIGHTS);
  localparam int ACC_W = FP_W + GUARD_BITS;

  typedef enum logic {ACCUM, COMMIT} wu_state_e;
  typedef logic signed [ACC_W-1:0] acc_t;

  wu_state_e    state_q, state_d;
  logic [SW-1:0] sweep_q, sweep_d;
  fixed_point_t weight_q [N_WEIGHTS];
  fixed_point_t weight_d [N_WEIGHTS];
  acc_t         acc_q    [N_WEIGHTS];
  acc_t         acc_d    [N_WEIGHTS];
  logic         done_q, done_d;
  logic         idx_err_q, idx_err_d;
  fixed_point_t rd_weight_q, rd_weight_d;
  fixed_point_t sweep_sum;

  // Accumulators clamp at the ACC_W limits rather than wrapping
  function automatic acc_t acc_add(input acc_t a, input logic [FP_W-1:0] d);
    logic signed [ACC_W:0] s;
    s = $signed({a[ACC_W-1], a}) + (ACC_W+1)'($signed(d));
    if (s[ACC_W] != s[ACC_W-1]) return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    return s[ACC_W-1:0];
  endfunction

  fp_sat_add #(.ACC_W(ACC_W)) u_sum (
    .acc    (acc_q[sweep_q]),
    .weight (weight_q[sweep_q]),
    .sum    (sweep_sum)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ACCUM;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM:  if (commit) state_d = COMMIT;
      COMMIT: if (sweep_q == SW'(N_WEIGHTS-1)) state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  always_comb begin
    busy        = (state_q == COMMIT);
    delta_ready = (state_q == ACCUM) && !rst;
  end

  always_comb begin
    sweep_d     = sweep_q;
    weight_d    = weight_q;
    acc_d       = acc_q;
    done_d      = 1'b0;
    idx_err_d   = idx_err_q;
    rd_weight_d = '0;
    if (rd_idx < IW'(N_WEIGHTS)) rd_weight_d = weight_q[rd_idx[SW-1:0]];
    if (state_q == ACCUM) begin
      if (ld_valid) begin
        if (ld_idx < IW'(N_WEIGHTS)) weight_d[ld_idx[SW-1:0]] = ld_weight;
        else                         idx_err_d = 1'b1;
      end
      if (delta_valid && delta_ready) begin
        if (delta_idx < IW'(N_WEIGHTS))
          acc_d[delta_idx[SW-1:0]] = acc_add(acc_q[delta_idx[SW-1:0]], weight_delta);
        else
          idx_err_d = 1'b1;
      end
      if (commit) sweep_d = '0;
    end else begin
      // One weight retired per cycle; its accumulator restarts from zero
      weight_d[sweep_q] = sweep_sum;
      acc_d[sweep_q]    = '0;
      if (sweep_q == SW'(N_WEIGHTS-1)) done_d = 1'b1;
      else                             sweep_d = sweep_q + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sweep_q     <= '0;
      weight_q    <= '{default: '0};
      acc_q       <= '{default: '0};
      done_q      <= 1'b0;
      idx_err_q   <= 1'b0;
      rd_weight_q <= '0;
    end else begin
      sweep_q     <= sweep_d;
      weight_q    <= weight_d;
      acc_q       <= acc_d;
      done_q      <= done_d;
      idx_err_q   <= idx_err_d;
      rd_weight_q <= rd_weight_d;
    end
  end

  assign done      = done_q;
  assign idx_err   = idx_err_q;
  assign rd_weight = rd_weight_q;

endmodule
